// File: rtl/game_round_controller.sv
// Wall-game round controller: frame-paced wall advance, goal-window collision
// thresholding, lives/score/speed bookkeeping, and a 1-cycle pixel pass-through.
module game_round_controller #(
    parameter int SCREEN_WIDTH             = 1280,
    parameter int SCREEN_HEIGHT            = 720,
    parameter int GOAL_DEPTH               = 60,
    parameter int GOAL_DEPTH_DELTA         = 10,
    parameter int MAX_WALL_DEPTH           = 75,
    parameter int MAX_FRAMES_PER_WALL_TICK = 15,
    parameter int MIN_FRAMES_PER_WALL_TICK = 2,
    parameter int NUM_LIVES                = 3,
    parameter int NUM_WALLS                = 10,
    parameter int COLLISION_THRESHOLD      = 64
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               start_in,
    input  logic [10:0]                        hcount_in,
    input  logic [9:0]                         vcount_in,
    input  logic                               data_valid_in,
    input  logic                               is_person_in,
    input  logic                               is_wall_in,
    output logic [10:0]                        hcount_out,
    output logic [9:0]                         vcount_out,
    output logic                               data_valid_out,
    output logic                               is_collision_out,
    output logic [7:0]                         wall_depth_out,
    output logic [3:0]                         wall_idx_out,
    output logic [7:0]                         round_out,
    output logic [$clog2(NUM_LIVES+1)-1:0]     lives_out,
    output logic [15:0]                        score_out,
    output logic [2:0]                         state_out
);
    localparam int LW = $clog2(NUM_LIVES + 1);
    localparam int FW = $clog2(MAX_FRAMES_PER_WALL_TICK + 1);

    localparam logic [10:0]   L_H_LAST      = 11'(SCREEN_WIDTH - 1);
    localparam logic [9:0]    L_V_LAST      = 10'(SCREEN_HEIGHT - 1);
    localparam logic [7:0]    L_CHECK_START = 8'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
    localparam logic [7:0]    L_CHECK_END   = 8'(GOAL_DEPTH + GOAL_DEPTH_DELTA + 1);
    localparam logic [7:0]    L_DEPTH_LAST  = 8'(MAX_WALL_DEPTH - 1);
    localparam logic [FW-1:0] L_MAX_FPT     = FW'(MAX_FRAMES_PER_WALL_TICK);
    localparam logic [FW-1:0] L_MIN_FPT     = FW'(MIN_FRAMES_PER_WALL_TICK);
    localparam logic [LW-1:0] L_LIVES       = LW'(NUM_LIVES);
    localparam logic [LW-1:0] L_ONE_LIFE    = LW'(1);
    localparam logic [3:0]    L_WALL_LAST   = 4'(NUM_WALLS - 1);
    localparam logic [15:0]   L_THRESH      = 16'(COLLISION_THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADVANCE   = 3'd1,
        S_CHECK     = 3'd2,
        S_ROUND_END = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic [7:0]    r_depth,     w_depth_nxt;
    logic [FW-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [FW-1:0] r_fpt,       w_fpt_nxt;
    logic [15:0]   r_hit_cnt,   w_hit_cnt_nxt;
    logic          r_hit_flag,  w_hit_flag_nxt;
    logic [7:0]    r_round,     w_round_nxt;
    logic [3:0]    r_wall_idx,  w_wall_idx_nxt;
    logic [15:0]   r_score,     w_score_nxt;
    logic [LW-1:0] r_lives,     w_lives_nxt;

    logic [10:0]   r_hcount;
    logic [9:0]    r_vcount;
    logic          r_valid;
    logic          r_coll;

    logic          w_pix_coll;
    logic          w_new_frame;
    logic          w_in_play;
    logic          w_tick;
    logic [7:0]    w_depth_inc;
    logic [16:0]   w_hit_sum;
    logic [15:0]   w_hit_total;
    logic          w_last_life;

    assign w_pix_coll  = data_valid_in & is_person_in & is_wall_in;
    assign w_new_frame = data_valid_in && (hcount_in == L_H_LAST) && (vcount_in == L_V_LAST);
    assign w_in_play   = (r_state == S_ADVANCE) || (r_state == S_CHECK);
    assign w_tick      = w_new_frame && w_in_play && (r_frame_cnt == r_fpt - 1'b1);
    assign w_depth_inc = r_depth + 8'd1;
    // The frame-end pixel itself contributes to that frame's total.
    assign w_hit_sum   = {1'b0, r_hit_cnt} + {16'd0, w_pix_coll};
    assign w_hit_total = w_hit_sum[16] ? 16'hFFFF : w_hit_sum[15:0];
    assign w_last_life = r_hit_flag && (r_lives == L_ONE_LIFE);

    always_comb begin
        w_state_nxt     = r_state;
        w_depth_nxt     = r_depth;
        w_frame_cnt_nxt = r_frame_cnt;
        w_fpt_nxt       = r_fpt;
        w_hit_cnt_nxt   = '0;
        w_hit_flag_nxt  = r_hit_flag;
        w_round_nxt     = r_round;
        w_wall_idx_nxt  = r_wall_idx;
        w_score_nxt     = r_score;
        w_lives_nxt     = r_lives;

        if (w_in_play && w_new_frame) begin
            w_frame_cnt_nxt = w_tick ? '0 : r_frame_cnt + 1'b1;
        end

        if (r_state == S_CHECK) begin
            if (w_new_frame) begin
                if (w_hit_total >= L_THRESH) begin
                    w_hit_flag_nxt = 1'b1;
                end
            end else begin
                w_hit_cnt_nxt = w_hit_total;
            end
        end

        case (r_state)
            S_IDLE, S_GAME_OVER: begin
                if (start_in) begin
                    w_state_nxt     = S_ADVANCE;
                    w_depth_nxt     = '0;
                    w_frame_cnt_nxt = '0;
                    w_round_nxt     = '0;
                    w_wall_idx_nxt  = '0;
                    w_score_nxt     = '0;
                    w_lives_nxt     = L_LIVES;
                    w_fpt_nxt       = L_MAX_FPT;
                    w_hit_flag_nxt  = 1'b0;
                    w_hit_cnt_nxt   = '0;
                end
            end
            S_ADVANCE: begin
                if (w_tick) begin
                    if (r_depth == L_DEPTH_LAST) begin
                        w_state_nxt = S_ROUND_END;
                    end else begin
                        w_depth_nxt = w_depth_inc;
                        if (w_depth_inc == L_CHECK_START) begin
                            w_state_nxt = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (w_tick) begin
                    w_depth_nxt = w_depth_inc;
                    if (w_depth_inc == L_CHECK_END) begin
                        w_state_nxt = S_ADVANCE;
                    end
                end
            end
            S_ROUND_END: begin
                if (r_hit_flag) begin
                    w_lives_nxt = r_lives - 1'b1;
                end else begin
                    w_score_nxt = (r_score != 16'hFFFF) ? r_score + 16'd1 : r_score;
                    w_fpt_nxt   = (r_fpt > L_MIN_FPT) ? r_fpt - 1'b1 : L_MIN_FPT;
                end
                // Game over freezes depth/round/wall_idx for display.
                if (w_last_life) begin
                    w_state_nxt = S_GAME_OVER;
                end else begin
                    w_state_nxt     = S_ADVANCE;
                    w_round_nxt     = r_round + 8'd1;
                    w_wall_idx_nxt  = (r_wall_idx == L_WALL_LAST) ? 4'd0 : r_wall_idx + 4'd1;
                    w_depth_nxt     = '0;
                    w_frame_cnt_nxt = '0;
                    w_hit_flag_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_depth     <= '0;
            r_frame_cnt <= '0;
            r_fpt       <= '0;
            r_hit_cnt   <= '0;
            r_hit_flag  <= 1'b0;
            r_round     <= '0;
            r_wall_idx  <= '0;
            r_score     <= '0;
            r_lives     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_depth     <= w_depth_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_fpt       <= w_fpt_nxt;
            r_hit_cnt   <= w_hit_cnt_nxt;
            r_hit_flag  <= w_hit_flag_nxt;
            r_round     <= w_round_nxt;
            r_wall_idx  <= w_wall_idx_nxt;
            r_score     <= w_score_nxt;
            r_lives     <= w_lives_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_valid  <= 1'b0;
            r_coll   <= 1'b0;
        end else begin
            r_hcount <= hcount_in;
            r_vcount <= vcount_in;
            r_valid  <= data_valid_in;
            r_coll   <= w_pix_coll;
        end
    end

    assign hcount_out       = r_hcount;
    assign vcount_out       = r_vcount;
    assign data_valid_out   = r_valid;
    assign is_collision_out = r_coll;
    assign wall_depth_out   = r_depth;
    assign wall_idx_out     = r_wall_idx;
    assign round_out        = r_round;
    assign lives_out        = r_lives;
    assign score_out        = r_score;
    assign state_out        = r_state;

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench for game_round_controller on an 8x4 screen: stimulus queues expected
// pixel outputs and per-frame game snapshots; the monitor checks them on each valid output.
module tb_game_round_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, dv, person, wallp;
    logic [10:0] hc;
    logic [9:0]  vc;

    logic [10:0] hc_out;
    logic [9:0]  vc_out;
    logic        dv_out, coll_out;
    logic [7:0]  depth_out, round_out;
    logic [3:0]  widx_out;
    logic [1:0]  lives_out;
    logic [15:0] score_out;
    logic [2:0]  state_out;

    game_round_controller #(
        .SCREEN_WIDTH(8), .SCREEN_HEIGHT(4), .GOAL_DEPTH(4), .GOAL_DEPTH_DELTA(1),
        .MAX_WALL_DEPTH(7), .MAX_FRAMES_PER_WALL_TICK(3), .MIN_FRAMES_PER_WALL_TICK(1),
        .NUM_LIVES(3), .NUM_WALLS(2), .COLLISION_THRESHOLD(2)
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .hcount_in(hc), .vcount_in(vc), .data_valid_in(dv),
        .is_person_in(person), .is_wall_in(wallp),
        .hcount_out(hc_out), .vcount_out(vc_out), .data_valid_out(dv_out),
        .is_collision_out(coll_out), .wall_depth_out(depth_out), .wall_idx_out(widx_out),
        .round_out(round_out), .lives_out(lives_out), .score_out(score_out),
        .state_out(state_out)
    );

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        coll;
        logic        eof;
    } pix_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  depth;
        logic [3:0]  widx;
        logic [7:0]  rnd;
        logic [1:0]  lives;
        logic [15:0] score;
    } snap_t;

    pix_t  pix_q[$];
    snap_t snap_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one queue entry per valid output pixel; frame-end pixels also pop a snapshot.
    pix_t  mp;
    snap_t ms;
    always @(negedge clk) begin
        if (!rst && dv_out === 1'b1) begin
            if (pix_q.size() == 0) begin
                check("unexpected_pixel", 32'd1, 32'd0);
            end else begin
                mp = pix_q.pop_front();
                check("pix_h", 32'(hc_out), 32'(mp.h));
                check("pix_v", 32'(vc_out), 32'(mp.v));
                check("pix_coll", 32'(coll_out), 32'(mp.coll));
                if (mp.eof) begin
                    if (snap_q.size() == 0) begin
                        check("missing_snapshot", 32'd1, 32'd0);
                    end else begin
                        ms = snap_q.pop_front();
                        check("state", 32'(state_out), 32'(ms.st));
                        check("depth", 32'(depth_out), 32'(ms.depth));
                        check("wall_idx", 32'(widx_out), 32'(ms.widx));
                        check("round", 32'(round_out), 32'(ms.rnd));
                        check("lives", 32'(lives_out), 32'(ms.lives));
                        check("score", 32'(score_out), 32'(ms.score));
                    end
                end
            end
        end
    end

    task automatic drive(bit v_, int h_, int vv, bit per, bit wl, bit st_);
        pix_t p;
        dv = v_; hc = 11'(h_); vc = 10'(vv); person = per; wallp = wl; start = st_;
        if (v_) begin
            p.h = 11'(h_); p.v = 10'(vv); p.coll = per & wl; p.eof = (h_ == 7 && vv == 3);
            pix_q.push_back(p);
        end
        @(negedge clk);
    endtask

    // ncoll collision pixels in the frame, the last one on the frame-end pixel.
    task automatic frame(int ncoll, snap_t exp, bit start_after);
        drive(1'b1, 0, 1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 2, 1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < ncoll; i++) drive(1'b1, 2 + i, 2, 1'b1, 1'b1, 1'b0);
        snap_q.push_back(exp);
        drive(1'b1, 7, 3, ncoll > 0, ncoll > 0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, start_after);
    endtask

    // Frame k of a round at f frames/step: depth k/f, CHECK at depths 3..5, ROUND_END at k=7f.
    task automatic run_round(int f, int n, int ncheck, int nout, int rnd, int widx,
                             int lv, int sc, int start_at);
        for (int k = 1; k <= n; k++) begin
            snap_t e;
            int d;
            d = k / f;
            e.depth = (k == 7 * f) ? 8'd6 : 8'(d);
            e.st    = (k == 7 * f) ? 3'd3 : ((d >= 3 && d <= 5) ? 3'd2 : 3'd1);
            e.widx  = 4'(widx); e.rnd = 8'(rnd); e.lives = 2'(lv); e.score = 16'(sc);
            frame((k > 3 * f && k <= 6 * f) ? ncheck : nout, e, k == start_at);
        end
    endtask

    task automatic over_frames(int n, int rnd, int widx, int sc);
        for (int k = 0; k < n; k++) begin
            snap_t e;
            e.st = 3'd4; e.depth = 8'd6; e.widx = 4'(widx); e.rnd = 8'(rnd);
            e.lives = 2'd0; e.score = 16'(sc);
            frame(2, e, 1'b0);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_state"}, 32'(state_out), 0);
        check({tag, "_depth"}, 32'(depth_out), 0);
        check({tag, "_widx"}, 32'(widx_out), 0);
        check({tag, "_round"}, 32'(round_out), 0);
        check({tag, "_lives"}, 32'(lives_out), 0);
        check({tag, "_score"}, 32'(score_out), 0);
        check({tag, "_pix"}, {hc_out, vc_out, dv_out, coll_out}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dv = 1'b0; hc = '0; vc = '0; person = 1'b0; wallp = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Game 1: clean, hit at threshold, clean at threshold-1, outside-window pixels, ramp floor.
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        run_round(3, 21, 0, 0, 0, 0, 3, 0, 0);
        run_round(2, 14, 2, 0, 1, 1, 3, 1, 0);
        run_round(2, 14, 1, 0, 2, 0, 2, 1, 0);
        run_round(1, 7, 0, 3, 3, 1, 2, 2, 0);
        run_round(1, 7, 0, 0, 4, 0, 2, 3, 0);
        run_round(1, 7, 3, 0, 5, 1, 2, 4, 0);
        run_round(1, 7, 2, 0, 6, 0, 1, 4, 0);
        over_frames(2, 6, 0, 4);

        // Game 2: restart from GAME_OVER, ignored start mid-round, three hits to game over.
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        run_round(3, 21, 2, 0, 0, 0, 3, 0, 5);
        run_round(3, 21, 2, 0, 1, 1, 2, 0, 0);
        run_round(3, 21, 2, 0, 2, 0, 1, 0, 0);
        over_frames(1, 2, 0, 0);

        // Game 3: stop at depth 4 inside the window, then asynchronous reset.
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        run_round(3, 12, 0, 0, 0, 0, 3, 0, 0);
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20 && (pix_q.size() != 0 || snap_q.size() != 0); i++) @(negedge clk);
        check("queue_drain", 32'(pix_q.size() + snap_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
